// File: rtl/sar_sync_ctrl.sv
// Synchronous SAR sequencer: sample phase, one comparator fire per bit,
// split high/low CAP DAC switch control, calibration mode, valid/busy/overrun.
module sar_sync_ctrl #(
  parameter int unsigned ADC_BITS   = 8,
  parameter int unsigned SAMPLE_CYC = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cal_en,
  input  logic [ADC_BITS-1:0] cal_code,
  input  logic                senamp_out,
  output logic                sample,
  output logic                cmp_fire,
  output logic [ADC_BITS-1:1] dac_data_h,
  output logic [ADC_BITS-1:1] dac_data_l,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                valid,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned JW  = $clog2(ADC_BITS);
  localparam int unsigned SMW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam int unsigned STW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    FIRE,
    EVAL,
    SETTLE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [JW-1:0]       j_q, j_d;
  logic [SMW-1:0]      smp_cnt_q, smp_cnt_d;
  logic [STW-1:0]      stl_cnt_q, stl_cnt_d;
  logic                cal_en_q, cal_en_d;
  logic [ADC_BITS-1:0] cal_code_q, cal_code_d;
  logic [ADC_BITS-1:0] result_q, result_d;
  logic [ADC_BITS-1:0] adc_q, adc_d;
  logic [ADC_BITS-1:1] dac_h_q, dac_h_d;
  logic [ADC_BITS-1:1] dac_l_q, dac_l_d;
  logic                decision;
  logic                accept;
  logic                busy_int;

  // Next-state, counters, result and DAC switch updates
  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    smp_cnt_d  = smp_cnt_q;
    stl_cnt_d  = stl_cnt_q;
    cal_en_d   = cal_en_q;
    cal_code_d = cal_code_q;
    result_d   = result_q;
    adc_d      = adc_q;
    dac_h_d    = dac_h_q;
    dac_l_d    = dac_l_q;
    decision   = 1'b0;
    accept     = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: ;
      SAMPLE: begin
        if (smp_cnt_q == '0) state_d = FIRE;
        else                 smp_cnt_d = smp_cnt_q - 1'b1;
      end
      FIRE: state_d = EVAL;
      EVAL: begin
        result_d[j_q] = senamp_out;
        decision      = cal_en_q ? cal_code_q[j_q] : senamp_out;
        if (j_q != '0) begin
          for (int unsigned i = 1; i < ADC_BITS; i++) begin
            if (JW'(ADC_BITS - i) == j_q) begin
              if (decision) dac_l_d[i] = 1'b1;
              else          dac_h_d[i] = 1'b1;
            end
          end
          j_d = j_q - 1'b1;
          if (SETTLE_CYC == 0) begin
            state_d = FIRE;
          end else begin
            state_d   = SETTLE;
            stl_cnt_d = STW'(SETTLE_CYC - 1);
          end
        end else begin
          // Loaded on the EVAL->DONE edge so adc_data changes together with valid.
          adc_d   = result_d;
          state_d = DONE;
        end
      end
      SETTLE: begin
        if (stl_cnt_q == '0) state_d = FIRE;
        else                 stl_cnt_d = stl_cnt_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cal_en_d   = cal_en;
      cal_code_d = cal_code;
      result_d   = '0;
      dac_h_d    = '0;
      dac_l_d    = '0;
      j_d        = JW'(ADC_BITS - 1);
      smp_cnt_d  = SMW'(SAMPLE_CYC - 1);
      state_d    = SAMPLE;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      j_q        <= '0;
      smp_cnt_q  <= '0;
      stl_cnt_q  <= '0;
      cal_en_q   <= 1'b0;
      cal_code_q <= '0;
      result_q   <= '0;
      adc_q      <= '0;
      dac_h_q    <= '0;
      dac_l_q    <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      smp_cnt_q  <= smp_cnt_d;
      stl_cnt_q  <= stl_cnt_d;
      cal_en_q   <= cal_en_d;
      cal_code_q <= cal_code_d;
      result_q   <= result_d;
      adc_q      <= adc_d;
      dac_h_q    <= dac_h_d;
      dac_l_q    <= dac_l_d;
    end
  end

  // State-decoded strobes and status outputs
  always_comb begin
    busy_int = (state_q == SAMPLE) || (state_q == FIRE) ||
               (state_q == EVAL)   || (state_q == SETTLE);
    sample   = (state_q == SAMPLE);
    cmp_fire = (state_q == FIRE);
    valid    = (state_q == DONE);
    busy     = busy_int;
    overrun  = start && busy_int;
  end

  assign dac_data_h = dac_h_q;
  assign dac_data_l = dac_l_q;
  assign adc_data   = adc_q;

endmodule

// File: tb/tb_sar_sync_ctrl.sv
// Self-checking bench for sar_sync_ctrl: default instance (8/2/1) and a
// small instance (4/1/0), per-cycle timing model plus result scoreboard.
module tb_sar_sync_ctrl;

  localparam int LAT_A = 26;
  localparam int SMP_A = 2;
  localparam int LAT_B = 10;
  localparam int SMP_B = 1;

  typedef struct {
    logic [15:0] adc;
    logic [15:0] l;
    logic [15:0] h;
    int          vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic       start_a, cal_en_a, sen_a;
  logic [7:0] cal_code_a;
  logic       sample_a, fire_a, valid_a, busy_a, ovr_a;
  logic [7:1] dh_a, dl_a;
  logic [7:0] adc_a;

  logic       start_b, cal_en_b, sen_b;
  logic [3:0] cal_code_b;
  logic       sample_b, fire_b, valid_b, busy_b, ovr_b;
  logic [3:1] dh_b, dl_b;
  logic [3:0] adc_b;

  logic [7:0] comp_a;
  logic [3:0] comp_b;
  int jm_a, jm_b;
  int cyc;
  int acc_a, acc_b;
  logic act_a, act_b;
  exp_t q_a[$];
  exp_t q_b[$];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sar_sync_ctrl #(.ADC_BITS(8), .SAMPLE_CYC(2), .SETTLE_CYC(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cal_en(cal_en_a),
    .cal_code(cal_code_a), .senamp_out(sen_a), .sample(sample_a),
    .cmp_fire(fire_a), .dac_data_h(dh_a), .dac_data_l(dl_a),
    .adc_data(adc_a), .valid(valid_a), .busy(busy_a), .overrun(ovr_a)
  );

  sar_sync_ctrl #(.ADC_BITS(4), .SAMPLE_CYC(1), .SETTLE_CYC(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cal_en(cal_en_b),
    .cal_code(cal_code_b), .senamp_out(sen_b), .sample(sample_b),
    .cmp_fire(fire_b), .dac_data_h(dh_b), .dac_data_l(dl_b),
    .adc_data(adc_b), .valid(valid_b), .busy(busy_b), .overrun(ovr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Expected result and DAC pattern from the comparator pattern and mode.
  function automatic exp_t mk(input int n, input logic [15:0] cmp, input logic cal,
                              input logic [15:0] cc, input int vc);
    exp_t e;
    e.adc = '0;
    e.l   = '0;
    e.h   = '0;
    e.vc  = vc;
    for (int j = n - 1; j >= 0; j--) begin
      e.adc[j] = cmp[j];
      if (j >= 1) begin
        if (cal ? cc[j] : cmp[j]) e.l[n-j-1] = 1'b1;
        else                      e.h[n-j-1] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic chk_zero();
    chk("rst_sample_a", 32'(sample_a), 0);
    chk("rst_fire_a",   32'(fire_a),   0);
    chk("rst_valid_a",  32'(valid_a),  0);
    chk("rst_busy_a",   32'(busy_a),   0);
    chk("rst_ovr_a",    32'(ovr_a),    0);
    chk("rst_dh_a",     32'(dh_a),     0);
    chk("rst_dl_a",     32'(dl_a),     0);
    chk("rst_adc_a",    32'(adc_a),    0);
    chk("rst_busy_b",   32'(busy_b),   0);
    chk("rst_dh_b",     32'(dh_b),     0);
    chk("rst_dl_b",     32'(dl_b),     0);
    chk("rst_adc_b",    32'(adc_b),    0);
  endtask

  // Checks outputs for the current cycle, updates models, advances one clock.
  task automatic step();
    int   r;
    logic bm, sm, fm, vx;
    exp_t e;
    #1;
    // default instance
    bm = act_a && cyc > acc_a && cyc < acc_a + LAT_A;
    sm = act_a && cyc > acc_a && cyc <= acc_a + SMP_A;
    r  = cyc - acc_a - 1 - SMP_A;
    fm = act_a && r >= 0 && (r % 3) == 0 && r <= 21;
    vx = 1'b0;
    if (q_a.size() > 0) vx = (q_a[0].vc == cyc);
    chk("busy_a",    32'(busy_a),   32'(bm));
    chk("sample_a",  32'(sample_a), 32'(sm));
    chk("fire_a",    32'(fire_a),   32'(fm));
    chk("overrun_a", 32'(ovr_a),    32'(start_a && bm));
    chk("disjoint_a", 32'(dh_a & dl_a), 0);
    chk("valid_a",   32'(valid_a),  32'(vx));
    if (valid_a && q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("adc_a", 32'(adc_a), 32'(e.adc));
      chk("dl_a",  32'(dl_a),  32'(e.l));
      chk("dh_a",  32'(dh_a),  32'(e.h));
    end
    if (rst) begin
      act_a = 1'b0;
      q_a.delete();
    end else if (start_a && !bm) begin
      acc_a = cyc;
      act_a = 1'b1;
      q_a.push_back(mk(8, 16'(comp_a), cal_en_a, 16'(cal_code_a), cyc + LAT_A));
    end
    if (sample_a) jm_a = 7;
    if (fire_a && jm_a >= 0) begin
      sen_a = comp_a[jm_a];
      jm_a--;
    end
    // small instance
    bm = act_b && cyc > acc_b && cyc < acc_b + LAT_B;
    r  = cyc - acc_b - 1 - SMP_B;
    fm = act_b && r >= 0 && (r % 2) == 0 && r <= 6;
    vx = 1'b0;
    if (q_b.size() > 0) vx = (q_b[0].vc == cyc);
    chk("busy_b",  32'(busy_b),  32'(bm));
    chk("fire_b",  32'(fire_b),  32'(fm));
    chk("valid_b", 32'(valid_b), 32'(vx));
    if (valid_b && q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("adc_b", 32'(adc_b), 32'(e.adc));
      chk("dl_b",  32'(dl_b),  32'(e.l));
      chk("dh_b",  32'(dh_b),  32'(e.h));
    end
    if (rst) begin
      act_b = 1'b0;
      q_b.delete();
    end else if (start_b && !bm) begin
      acc_b = cyc;
      act_b = 1'b1;
      q_b.push_back(mk(4, 16'(comp_b), cal_en_b, 16'(cal_code_b), cyc + LAT_B));
    end
    if (sample_b) jm_b = 3;
    if (fire_b && jm_b >= 0) begin
      sen_b = comp_b[jm_b];
      jm_b--;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; cal_en_a = 1'b0; cal_code_a = '0; sen_a = 1'b0;
    start_b = 1'b0; cal_en_b = 1'b0; cal_code_b = '0; sen_b = 1'b0;
    comp_a = '0; comp_b = '0;
    jm_a = -1; jm_b = -1;
    acc_a = 0; acc_b = 0; act_a = 1'b0; act_b = 1'b0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    rst = 1'b0;

    // Normal conversions: 0xA5 on the default instance, 0x9 on the small one
    comp_a = 8'hA5; comp_b = 4'h9;
    start_a = 1'b1; start_b = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    repeat (27) step();

    // Calibration mode; cal inputs change after acceptance to prove capture
    comp_a = 8'hFF; cal_en_a = 1'b1; cal_code_a = 8'h0F;
    start_a = 1'b1;
    step();
    start_a = 1'b0; cal_en_a = 1'b0; cal_code_a = 8'hF0;
    repeat (27) step();

    // Start pulses while busy at relative cycles 5 and 12
    comp_a = 8'h3C;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (4) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (6) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (15) step();

    // Start held high: back-to-back conversions with no idle gap
    comp_a = 8'h5A;
    start_a = 1'b1;
    repeat (78) step();
    start_a = 1'b0;
    repeat (2) step();

    // Reset in mid-conversion, then a fresh conversion on both instances
    comp_a = 8'hC3;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero();
    repeat (30) step();
    comp_a = 8'h81; comp_b = 4'h6;
    start_a = 1'b1; start_b = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    repeat (27) step();

    chk("pending_a", 32'(q_a.size()), 0);
    chk("pending_b", 32'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
